// File: rtl/conv_2d_pkg.sv
// Shared types and default geometry for the multi-channel convolution sequencer.
package conv_2d_pkg;

    localparam int unsigned DefConvoWidth  = 3;
    localparam int unsigned DefConvoHeight = 3;
    localparam int unsigned KernelSize     = DefConvoWidth * DefConvoHeight;

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        LAUNCH,
        WAIT_DONE,
        NEXT,
        DONE_REQ,
        DONE_REL
    } seq_state_e;

    typedef struct packed {
        logic err_cfg;
        logic err_timeout;
        logic aborted;
    } seq_status_t;

endpackage

// File: rtl/conv_2d_base_gen.sv
// Channel index and weight/output base accumulators; clear wins over step.
// Registered outputs update the cycle after clr_i/step_i; no backpressure.
module conv_2d_base_gen #(
    parameter int unsigned ChCntWidth   = 3,
    parameter int unsigned WgtAddrWidth = 6,
    parameter int unsigned OutAddrWidth = 12,
    parameter int unsigned WgtStride    = 9,
    parameter int unsigned OutStride    = 676
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clr_i,
    input  logic                    step_i,
    output logic [ChCntWidth-1:0]   ch_o,
    output logic [WgtAddrWidth-1:0] wgt_base_o,
    output logic [OutAddrWidth-1:0] out_base_o
);

    logic [ChCntWidth-1:0]   ch_q,  ch_d;
    logic [WgtAddrWidth-1:0] wgt_q, wgt_d;
    logic [OutAddrWidth-1:0] out_q, out_d;

    // Strides are added rather than multiplied; the last channel's base fits by construction.
    always_comb begin
        ch_d  = ch_q;
        wgt_d = wgt_q;
        out_d = out_q;
        if (clr_i) begin
            ch_d  = '0;
            wgt_d = '0;
            out_d = '0;
        end else if (step_i) begin
            ch_d  = ch_q + ChCntWidth'(1);
            wgt_d = wgt_q + WgtAddrWidth'(WgtStride);
            out_d = out_q + OutAddrWidth'(OutStride);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ch_q  <= '0;
            wgt_q <= '0;
            out_q <= '0;
        end else begin
            ch_q  <= ch_d;
            wgt_q <= wgt_d;
            out_q <= out_d;
        end
    end

    assign ch_o       = ch_q;
    assign wgt_base_o = wgt_q;
    assign out_base_o = out_q;

endmodule

// File: rtl/conv_2d_seq_ctrl.sv
// Four-phase host handshake that launches the convolution engine once per output channel.
// All outputs registered; engine launch 2 cycles after the previous done; engine has no backpressure beyond done/timeout.
module conv_2d_seq_ctrl
    import conv_2d_pkg::*;
#(
    parameter int unsigned NumChannels   = 4,
    parameter int unsigned ConvoWidth    = DefConvoWidth,
    parameter int unsigned ConvoHeight   = DefConvoHeight,
    parameter int unsigned DataSizeW     = 28,
    parameter int unsigned DataSizeH     = 28,
    parameter int unsigned OutMapSize    = (DataSizeW - ConvoWidth + 1) * (DataSizeH - ConvoHeight + 1),
    parameter int unsigned WgtAddrWidth  = $clog2(NumChannels * ConvoWidth * ConvoHeight),
    parameter int unsigned OutAddrWidth  = $clog2(NumChannels * OutMapSize),
    parameter int unsigned ChCntWidth    = $clog2(NumChannels + 1),
    parameter int unsigned TimeoutCycles = 4096
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    req_i,
    output logic                    ack_o,
    output logic                    req_o,
    input  logic                    ack_i,
    input  logic                    abort_i,
    input  logic [ChCntWidth-1:0]   num_ch_i,
    output logic                    eng_start_o,
    input  logic                    eng_done_i,
    output logic [ChCntWidth-1:0]   eng_ch_o,
    output logic [WgtAddrWidth-1:0] eng_wgt_base_o,
    output logic [OutAddrWidth-1:0] eng_out_base_o,
    output logic                    busy_o,
    output logic [ChCntWidth-1:0]   ch_done_cnt_o,
    output logic                    err_cfg_o,
    output logic                    err_timeout_o,
    output logic                    aborted_o
);

    localparam int unsigned WgtStride = ConvoWidth * ConvoHeight;
    localparam int unsigned TmoWidth  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TimeoutCycles - 1);

    seq_state_e             state_q, state_d;
    logic [ChCntWidth-1:0]  num_ch_q, num_ch_d;
    logic                   no_launch_q, no_launch_d;
    logic [ChCntWidth-1:0]  done_cnt_q, done_cnt_d;
    logic [TmoWidth-1:0]    tmo_q, tmo_d;
    seq_status_t            status_q, status_d;
    logic                   ack_q, ack_d;
    logic                   req_q, req_d;
    logic                   start_q, start_d;
    logic                   busy_q, busy_d;
    logic                   cfg_bad;
    logic                   last_ch;
    logic                   gen_clr;
    logic                   gen_step;

    conv_2d_base_gen #(
        .ChCntWidth   (ChCntWidth),
        .WgtAddrWidth (WgtAddrWidth),
        .OutAddrWidth (OutAddrWidth),
        .WgtStride    (WgtStride),
        .OutStride    (OutMapSize)
    ) u_base_gen (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clr_i      (gen_clr),
        .step_i     (gen_step),
        .ch_o       (eng_ch_o),
        .wgt_base_o (eng_wgt_base_o),
        .out_base_o (eng_out_base_o)
    );

    assign cfg_bad = (num_ch_i == '0) || (num_ch_i > ChCntWidth'(NumChannels));
    assign last_ch = ((eng_ch_o + ChCntWidth'(1)) == num_ch_q);

    always_comb begin
        state_d     = state_q;
        num_ch_d    = num_ch_q;
        no_launch_d = no_launch_q;
        done_cnt_d  = done_cnt_q;
        tmo_d       = tmo_q;
        status_d    = status_q;
        gen_clr     = 1'b0;
        gen_step    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    num_ch_d    = num_ch_i;
                    no_launch_d = cfg_bad;
                    done_cnt_d  = '0;
                    status_d    = '{err_cfg: cfg_bad, err_timeout: 1'b0, aborted: 1'b0};
                    gen_clr     = 1'b1;
                    state_d     = ACK;
                end
            end
            ACK: begin
                if (!req_i) begin
                    state_d = no_launch_q ? DONE_REQ : LAUNCH;
                end
            end
            LAUNCH: begin
                tmo_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tmo_q != '1) begin
                    tmo_d = tmo_q + TmoWidth'(1);
                end
                // Done beats abort beats timeout; a coincident abort still ends the run.
                if (eng_done_i) begin
                    done_cnt_d = done_cnt_q + ChCntWidth'(1);
                    if (abort_i) begin
                        status_d.aborted = 1'b1;
                        state_d          = DONE_REQ;
                    end else begin
                        state_d = last_ch ? DONE_REQ : NEXT;
                    end
                end else if (abort_i) begin
                    status_d.aborted = 1'b1;
                    state_d          = DONE_REQ;
                end else if (tmo_q == TmoLast) begin
                    status_d.err_timeout = 1'b1;
                    state_d              = DONE_REQ;
                end
            end
            NEXT: begin
                gen_step = 1'b1;
                state_d  = LAUNCH;
            end
            DONE_REQ: begin
                if (ack_i) begin
                    state_d = DONE_REL;
                end
            end
            DONE_REL: begin
                if (!ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ack_d   = (state_d == ACK);
        start_d = (state_d == LAUNCH);
        req_d   = (state_d == DONE_REQ);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            num_ch_q    <= '0;
            no_launch_q <= 1'b0;
            done_cnt_q  <= '0;
            tmo_q       <= '0;
            status_q    <= '0;
            ack_q       <= 1'b0;
            req_q       <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_ch_q    <= num_ch_d;
            no_launch_q <= no_launch_d;
            done_cnt_q  <= done_cnt_d;
            tmo_q       <= tmo_d;
            status_q    <= status_d;
            ack_q       <= ack_d;
            req_q       <= req_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
        end
    end

    assign ack_o         = ack_q;
    assign req_o         = req_q;
    assign eng_start_o   = start_q;
    assign busy_o        = busy_q;
    assign ch_done_cnt_o = done_cnt_q;
    assign err_cfg_o     = status_q.err_cfg;
    assign err_timeout_o = status_q.err_timeout;
    assign aborted_o     = status_q.aborted;

endmodule

// File: tb/tb_conv_2d_seq_ctrl.sv
// Directed bench for the convolution sequencer: handshake, multi-channel run, config error, timeout, abort, reset.
module tb_conv_2d_seq_ctrl;

    localparam int CW = 3;
    localparam int WW = 6;
    localparam int OW = 12;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          req_i;
    logic          ack_o;
    logic          req_o;
    logic          ack_i;
    logic          abort_i;
    logic [CW-1:0] num_ch_i;
    logic          eng_start_o;
    logic          eng_done_i;
    logic [CW-1:0] eng_ch_o;
    logic [WW-1:0] eng_wgt_base_o;
    logic [OW-1:0] eng_out_base_o;
    logic          busy_o;
    logic [CW-1:0] ch_done_cnt_o;
    logic          err_cfg_o;
    logic          err_timeout_o;
    logic          aborted_o;

    logic eng_done_auto = 1'b0;
    logic eng_done_man  = 1'b0;
    logic eng_auto      = 1'b0;
    assign eng_done_i = eng_done_auto | eng_done_man;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_at  = -1;
    int nstart   = 0;
    int nbase    = 0;
    int req_rise_cyc = 0;
    logic req_prev = 1'b0;
    int st_cyc [32];
    int st_ch  [32];
    int st_wgt [32];
    int st_out [32];

    conv_2d_seq_ctrl #(.TimeoutCycles(16)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .req_i          (req_i),
        .ack_o          (ack_o),
        .req_o          (req_o),
        .ack_i          (ack_i),
        .abort_i        (abort_i),
        .num_ch_i       (num_ch_i),
        .eng_start_o    (eng_start_o),
        .eng_done_i     (eng_done_i),
        .eng_ch_o       (eng_ch_o),
        .eng_wgt_base_o (eng_wgt_base_o),
        .eng_out_base_o (eng_out_base_o),
        .busy_o         (busy_o),
        .ch_done_cnt_o  (ch_done_cnt_o),
        .err_cfg_o      (err_cfg_o),
        .err_timeout_o  (err_timeout_o),
        .aborted_o      (aborted_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Start-pulse recorder plus an engine that answers 10 cycles after each launch.
    always @(negedge clk_i) begin
        if (eng_start_o) begin
            if (nstart < 32) begin
                st_cyc[nstart] = cyc;
                st_ch[nstart]  = int'(eng_ch_o);
                st_wgt[nstart] = int'(eng_wgt_base_o);
                st_out[nstart] = int'(eng_out_base_o);
            end
            nstart = nstart + 1;
            if (eng_auto) done_at = cyc + 10;
        end
        eng_done_auto = eng_auto && (cyc == done_at);
        if (req_o && !req_prev) req_rise_cyc = cyc;
        req_prev = req_o;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [CW-1:0] n);
        num_ch_i = n;
        req_i    = 1'b1;
        tick(1);
        req_i    = 1'b0;
        tick(1);
    endtask

    task automatic finish_run();
        int k;
        k = 0;
        while (!req_o && k < 300) begin
            tick(1);
            k++;
        end
        check("fin_req_wait", req_o, 1);
        ack_i = 1'b1;
        tick(1);
        check("fin_req_drop", req_o, 0);
        ack_i = 1'b0;
        tick(1);
        check("fin_busy_end", busy_o, 0);
    endtask

    initial begin
        int k;
        reset_i  = 1'b1;
        req_i    = 1'b0;
        ack_i    = 1'b0;
        abort_i  = 1'b0;
        num_ch_i = '0;
        tick(3);
        check("rst_ctl", {ack_o, req_o, eng_start_o, busy_o, err_cfg_o, err_timeout_o, aborted_o}, 0);
        check("rst_dat", {eng_ch_o, eng_wgt_base_o, eng_out_base_o, ch_done_cnt_o}, 0);
        reset_i = 1'b0;
        tick(1);

        // Three-channel run with a held start request.
        eng_auto = 1'b1;
        nbase    = nstart;
        num_ch_i = 3'd3;
        req_i    = 1'b1;
        tick(1);
        check("hs_ack_rise", ack_o, 1);
        check("hs_busy_rise", busy_o, 1);
        tick(4);
        check("hs_ack_hold", ack_o, 1);
        check("hs_no_start", nstart - nbase, 0);
        req_i = 1'b0;
        tick(1);
        check("hs_ack_drop", ack_o, 0);
        check("hs_start", eng_start_o, 1);
        k = 0;
        while (!req_o && k < 200) begin
            tick(1);
            k++;
        end
        check("run3_req", req_o, 1);
        check("run3_cnt", ch_done_cnt_o, 3);
        tick(3);
        check("run3_req_held", req_o, 1);
        check("run3_nstart", nstart - nbase, 3);
        check("run3_wgt0", st_wgt[nbase], 0);
        check("run3_wgt1", st_wgt[nbase+1], 9);
        check("run3_wgt2", st_wgt[nbase+2], 18);
        check("run3_out0", st_out[nbase], 0);
        check("run3_out1", st_out[nbase+1], 676);
        check("run3_out2", st_out[nbase+2], 1352);
        check("run3_ch2", st_ch[nbase+2], 2);
        check("run3_gap", st_cyc[nbase+1] - st_cyc[nbase], 12);
        check("run3_gap2", st_cyc[nbase+2] - st_cyc[nbase+1], 12);
        check("run3_req_lat", req_rise_cyc - st_cyc[nbase+2], 11);
        ack_i = 1'b1;
        tick(1);
        check("cmp_req_drop", req_o, 0);
        check("cmp_busy_rel", busy_o, 1);
        tick(2);
        check("cmp_busy_hold", busy_o, 1);
        ack_i = 1'b0;
        tick(1);
        check("cmp_busy_end", busy_o, 0);
        check("cmp_cnt_kept", ch_done_cnt_o, 3);

        // Illegal channel counts never launch the engine.
        nbase = nstart;
        start_run(3'd0);
        check("cfg0_err", err_cfg_o, 1);
        check("cfg0_req", req_o, 1);
        finish_run();
        start_run(3'd5);
        check("cfg5_err", err_cfg_o, 1);
        finish_run();
        check("cfg_no_start", nstart - nbase, 0);
        check("cfg_err_kept", err_cfg_o, 1);
        start_run(3'd1);
        check("cfg_err_clr", err_cfg_o, 0);
        finish_run();
        check("cfg_one_start", nstart - nbase, 1);

        // Silent engine: 16 cycles in WAIT_DONE then timeout.
        eng_auto = 1'b0;
        start_run(3'd1);
        tick(16);
        check("tmo_not_yet", {err_timeout_o, req_o}, 0);
        tick(1);
        check("tmo_err", err_timeout_o, 1);
        check("tmo_req", req_o, 1);
        check("tmo_cnt", ch_done_cnt_o, 0);
        finish_run();

        // Abort coinciding with the second done.
        nbase = nstart;
        start_run(3'd4);
        check("abd_tmo_clr", err_timeout_o, 0);
        tick(3);
        eng_done_man = 1'b1;
        tick(1);
        eng_done_man = 1'b0;
        check("abd_cnt1", ch_done_cnt_o, 1);
        tick(1);
        check("abd_start_ch1", {eng_start_o, eng_ch_o}, {1'b1, 3'd1});
        check("abd_wgt1", eng_wgt_base_o, 9);
        tick(2);
        eng_done_man = 1'b1;
        abort_i      = 1'b1;
        tick(1);
        eng_done_man = 1'b0;
        abort_i      = 1'b0;
        check("abd_cnt2", ch_done_cnt_o, 2);
        check("abd_aborted", aborted_o, 1);
        check("abd_req", req_o, 1);
        finish_run();
        check("abd_nstart", nstart - nbase, 2);

        // Abort alone in the middle of the second channel.
        start_run(3'd4);
        check("ab_clr", {aborted_o, ch_done_cnt_o}, 0);
        tick(3);
        eng_done_man = 1'b1;
        tick(1);
        eng_done_man = 1'b0;
        tick(3);
        abort_i = 1'b1;
        tick(1);
        abort_i = 1'b0;
        check("ab_cnt", ch_done_cnt_o, 1);
        check("ab_aborted", aborted_o, 1);
        check("ab_req", req_o, 1);
        finish_run();

        // Reset in WAIT_DONE, late done ignored, clean restart.
        start_run(3'd2);
        tick(3);
        reset_i = 1'b1;
        tick(1);
        reset_i = 1'b0;
        check("mrst_ctl", {ack_o, req_o, eng_start_o, busy_o, err_cfg_o, err_timeout_o, aborted_o}, 0);
        check("mrst_dat", {eng_ch_o, eng_wgt_base_o, eng_out_base_o, ch_done_cnt_o}, 0);
        eng_done_man = 1'b1;
        tick(1);
        eng_done_man = 1'b0;
        tick(1);
        check("late_done", {busy_o, eng_start_o, ch_done_cnt_o}, 0);
        eng_auto = 1'b1;
        nbase    = nstart;
        start_run(3'd2);
        finish_run();
        check("rerun_nstart", nstart - nbase, 2);
        check("rerun_ch0", st_ch[nbase], 0);
        check("rerun_ch1", st_ch[nbase+1], 1);
        check("rerun_out1", st_out[nbase+1], 676);
        check("rerun_cnt", ch_done_cnt_o, 2);
        check("rerun_flags", {err_cfg_o, err_timeout_o, aborted_o}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_2d_seq_ctrl.md
Name: conv_2d_seq_ctrl

Overview:
Multi-channel sequencer for the 2-D convolution engine. It replaces the GPIO bit-banged req/ack control with a self-contained four-phase host handshake. After one host start it launches the engine once per output channel, up to NumChannels, and generates per-channel weight and output RAM base addresses. It adds abort, runtime channel count, timeout and status, none of which the single-shot flow has; it sits between the PS GPIO block and the convolution core.

Parameters:
NumChannels, 4, max output channels (filters) per run
ConvoWidth, 3, kernel width
ConvoHeight, 3, kernel height
DataSizeW, 28, input map width
DataSizeH, 28, input map height
OutMapSize, (DataSizeW-ConvoWidth+1)*(DataSizeH-ConvoHeight+1), output words per channel (676)
WgtAddrWidth, $clog2(NumChannels*ConvoWidth*ConvoHeight), weight RAM address width
OutAddrWidth, $clog2(NumChannels*OutMapSize), output RAM address width
ChCntWidth, $clog2(NumChannels+1), channel count width
TimeoutCycles, 4096, max cycles waiting for engine done

Ports:
clk_i  in  1  system clock
reset_i  in  1  synchronous active-high reset
req_i  in  1  host start request (four-phase)
ack_o  out  1  start acknowledge
req_o  out  1  run-complete request to host
ack_i  in  1  host acknowledge of completion
abort_i  in  1  host abort, level sampled
num_ch_i  in  ChCntWidth  channels to run, sampled on start
eng_start_o  out  1  one-cycle engine launch pulse
eng_done_i  in  1  one-cycle engine completion pulse
eng_ch_o  out  ChCntWidth  current channel index
eng_wgt_base_o  out  WgtAddrWidth  weight base = ch*ConvoWidth*ConvoHeight
eng_out_base_o  out  OutAddrWidth  output base = ch*OutMapSize
busy_o  out  1  high from start accept until return to IDLE
ch_done_cnt_o  out  ChCntWidth  channels completed this run
err_cfg_o  out  1  sticky: illegal num_ch_i
err_timeout_o  out  1  sticky: engine timeout
aborted_o  out  1  sticky: run aborted

Behaviour:
- Reset (synchronous, reset_i=1 at clk_i edge): state IDLE; every output 0; counters 0. Reset mid-run drops to IDLE immediately with no handshake completion. All outputs are registered.
- States: IDLE, ACK, LAUNCH, WAIT_DONE, NEXT, DONE_REQ, DONE_REL.
- IDLE: on req_i=1, latch num_ch_i, clear err_*/aborted_o/ch_done_cnt_o/ch/bases, then go to ACK. ack_o=1 and busy_o=1 from the next cycle. If num_ch_i==0 or num_ch_i>NumChannels, set err_cfg_o; the run is flagged no-launch.
- ACK: hold ack_o=1 until req_i=0. On the cycle req_i=0 is seen, drop ack_o. Go to DONE_REQ if the run is flagged no-launch, otherwise go to LAUNCH.
- LAUNCH: eng_start_o=1 for exactly one cycle. eng_ch_o and the bases are already valid and stable for the whole channel. Timeout counter cleared. Go to WAIT_DONE.
- WAIT_DONE: the timeout counter increments each cycle.
  - On eng_done_i: ch_done_cnt_o++. If ch==num_ch-1 go to DONE_REQ, else go to NEXT.
  - Else if abort_i: set aborted_o and go to DONE_REQ.
  - Else if the counter reaches TimeoutCycles-1: set err_timeout_o and go to DONE_REQ.
- Priority in the same cycle: done > abort > timeout. If done and abort coincide, the channel counts and the run then ends aborted, with no further launch.
- abort_i in LAUNCH: the pulse still issues, and the abort is acted on in WAIT_DONE.
- NEXT: ch++, wgt_base += ConvoWidth*ConvoHeight, out_base += OutMapSize. Use accumulators, no multipliers. Go to LAUNCH. Gap from eng_done_i to the next eng_start_o is 2 cycles.
- DONE_REQ: req_o=1 until ack_i=1, then req_o=0 and go to DONE_REL.
- DONE_REL: wait for ack_i=0, then go to IDLE with busy_o=0.
- Status registers keep their values after IDLE until the next accepted start.
- eng_done_i outside WAIT_DONE is ignored. req_i held high after ACK is not a new start. Each start needs req_i low-then-high via IDLE.
- Widths: base accumulators never exceed (NumChannels-1)*stride, so they cannot overflow their declared widths. The timeout counter is $clog2(TimeoutCycles) bits and saturates.

Decomposition:
- conv_2d_pkg: seq_state_e enum, KernelSize=ConvoWidth*ConvoHeight constant, and a status struct {err_cfg, err_timeout, aborted}.
- Sub-module conv_2d_base_gen: channel index plus the two stride accumulators, with clear/step inputs. The FSM and handshake stay in the top.

Test Plan:
- num_ch_i=3 with an engine model that returns done 10 cycles after start:
  - Three eng_start_o pulses, with eng_wgt_base_o=0,9,18 and eng_out_base_o=0,676,1352.
  - 2-cycle done-to-start gap.
  - req_o rises 1 cycle after the third done; ch_done_cnt_o=3.
- Handshake: req_i high → ack_o=1 next cycle. Hold req_i for 5 cycles → ack_o held high and no start pulse. Drop req_i → ack_o=0 and eng_start_o the following cycle. Completion: req_o held until ack_i=1, busy_o=0 only after ack_i=0.
- num_ch_i=0 and num_ch_i=5 → err_cfg_o=1, no eng_start_o, handshake completes normally. A following valid start clears err_cfg_o.
- Engine never sends done, TimeoutCycles=16 → err_timeout_o=1 after 16 cycles in WAIT_DONE, then req_o=1.
- num_ch_i=4:
  - abort_i on the same cycle as the second done → ch_done_cnt_o=2, aborted_o=1, no third start.
  - abort alone mid-channel → ch_done_cnt_o unchanged.
- reset_i asserted in WAIT_DONE → next cycle all outputs 0 and state IDLE. A late eng_done_i is ignored, and a new start runs cleanly from channel 0.
